// File: rtl/ex_stage_md_pkg.sv
// ex_stage_md_pkg: shared encodings, FSM states and default widths for the mul/div execute stage.
package ex_stage_md_pkg;
    localparam int XLEN_DEF = 32;
    localparam int RWB_LEN = 6;
    localparam int MCB_LEN = 4;
    localparam int MD_NONE = 0;
    localparam int MD_MULT = 1;
    localparam int MD_MULTU = 2;
    localparam int MD_DIV = 3;
    localparam int MD_DIVU = 4;
    localparam int MD_MFHI = 5;
    localparam int MD_MFLO = 6;
    localparam int MD_MTHI = 7;
    localparam int MD_MTLO = 8;
    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_AND = 2;
    localparam int ALU_OR = 3;
    localparam int ALU_XOR = 4;
    localparam int ALU_NOR = 5;
    localparam int ALU_SLT = 6;
    localparam int ALU_SLTU = 7;
    localparam int ALU_SLL = 8;
    localparam int ALU_SRL = 9;
    localparam int ALU_SRA = 10;
    typedef enum logic [1:0] {MD_IDLE = 2'd0, MD_CALC = 2'd1, MD_FIX = 2'd2} md_state_t;
    function automatic logic is_iter_op(input int op);
        return op >= MD_MULT && op <= MD_DIVU;
    endfunction
endpackage

// File: rtl/alu.sv
// alu: single-cycle integer ALU; shifts act on b by shamt.
module alu
    import ex_stage_md_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ALU_OP_W = 4
) (
    input  logic [ALU_OP_W-1:0] op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    input  logic [4:0]          shamt,
    output logic [XLEN-1:0]     y
);
    always_comb begin
        case (int'(op))
            ALU_ADD:  y = a + b;
            ALU_SUB:  y = a - b;
            ALU_AND:  y = a & b;
            ALU_OR:   y = a | b;
            ALU_XOR:  y = a ^ b;
            ALU_NOR:  y = ~(a | b);
            ALU_SLT:  y = XLEN'($signed(a) < $signed(b));
            ALU_SLTU: y = XLEN'(a < b);
            ALU_SLL:  y = b << shamt;
            ALU_SRL:  y = b >> shamt;
            ALU_SRA:  y = $signed(b) >>> shamt;
            default:  y = '0;
        endcase
    end
endmodule

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 multiply/divide on magnitudes; the last step and sign fix happen combinationally in FIX.
module muldiv_iter
    import ex_stage_md_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int MD_OP_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [MD_OP_W-1:0] op,
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    output logic               busy,
    output logic               done,
    output logic [XLEN-1:0]    hi,
    output logic [XLEN-1:0]    lo
);
    localparam int CW = $clog2(XLEN + 1);
    md_state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [XLEN-1:0] acc, q, m, step_acc, step_q;
    logic is_div, neg_q, neg_r, dz, signed_op, sa, sb;
    logic [XLEN:0] sum, rs, diff;
    logic [2*XLEN-1:0] prod;
    assign signed_op = int'(op) == MD_MULT || int'(op) == MD_DIV;
    assign sa = signed_op & a[XLEN-1];
    assign sb = signed_op & b[XLEN-1];
    always_comb begin
        state_n = abort ? MD_IDLE
                : state == MD_IDLE ? (start ? MD_CALC : MD_IDLE)
                : state == MD_CALC ? (cnt == CW'(2) ? MD_FIX : MD_CALC)
                : MD_IDLE;
        busy = start || state != MD_IDLE;
        done = state == MD_FIX && !abort;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= MD_IDLE;
        else state <= state_n;
    end
    always_comb begin
        sum = {1'b0, acc} + {1'b0, q[0] ? m : '0};
        rs = {acc, q[XLEN-1]};
        diff = rs - {1'b0, m};
        step_acc = is_div ? (diff[XLEN] ? rs[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
        step_q = is_div ? {q[XLEN-2:0], !diff[XLEN]} : {sum[0], q[XLEN-1:1]};
        prod = neg_q ? -{step_acc, step_q} : {step_acc, step_q};
        hi = is_div ? (neg_r ? -step_acc : step_acc) : prod[2*XLEN-1:XLEN];
        lo = is_div ? (dz ? '1 : neg_q ? -step_q : step_q) : prod[XLEN-1:0];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            acc <= '0;
            q <= '0;
            m <= '0;
            is_div <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
        end else if (state == MD_IDLE && start) begin
            cnt <= CW'(XLEN);
            acc <= '0;
            q <= sa ? -a : a;
            m <= sb ? -b : b;
            is_div <= int'(op) == MD_DIV || int'(op) == MD_DIVU;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            dz <= b == '0;
        end else if (state == MD_CALC) begin
            cnt <= cnt - CW'(1);
            acc <= step_acc;
            q <= step_q;
        end
    end
endmodule

// File: rtl/ex_stage_md.sv
// ex_stage_md: execute stage with ID/EX latch, forwarding, ALU, HI/LO and an iterative mul/div that stalls the pipe.
module ex_stage_md
    import ex_stage_md_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int ALU_OP_W = 4,
    parameter int MD_OP_W = 4,
    parameter int REG_WRITE_BUS_LENGTH = RWB_LEN,
    parameter int MEM_CONTRAL_BUS_LENGTH = MCB_LEN
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pipeline_flush,
    input  logic                              pipeline_ready,
    output logic                              pipeline_valid,
    input  logic [XLEN-1:0]                   pc_plus_4_i,
    input  logic                              s_link_i,
    input  logic                              s_lui_i,
    input  logic                              s_rs_bypass_i,
    input  logic                              s_alu_imm_i,
    input  logic                              s_shamt_reg_i,
    input  logic                              s_syscall_i,
    input  logic [ALU_OP_W-1:0]               alu_op_i,
    input  logic [MD_OP_W-1:0]                md_op_i,
    input  logic [4:0]                        shamt_i,
    input  logic [XLEN-1:0]                   extended_imm_i,
    input  logic [XLEN-1:0]                   d_rs_i,
    input  logic [XLEN-1:0]                   d_rt_i,
    input  logic                              s_rs_fastforward,
    input  logic                              s_rt_fastforward,
    input  logic [XLEN-1:0]                   d_rs_fastforward,
    input  logic [XLEN-1:0]                   d_rt_fastforward,
    input  logic [REG_WRITE_BUS_LENGTH-1:0]   s_reg_write_bus_i,
    output logic [REG_WRITE_BUS_LENGTH-1:0]   s_reg_write_bus,
    input  logic [MEM_CONTRAL_BUS_LENGTH-1:0] s_mem_contral_bus_i,
    output logic [MEM_CONTRAL_BUS_LENGTH-1:0] s_mem_contral_bus,
    output logic [XLEN-1:0]                   ex_result,
    output logic [XLEN-1:0]                   rt_bypass,
    output logic                              s_syscall,
    output logic [XLEN-1:0]                   syscall_data_o,
    output logic [XLEN-1:0]                   display_data_o
);
    logic s_link, s_lui, s_rs_bypass, s_alu_imm, s_shamt_reg;
    logic [ALU_OP_W-1:0] alu_op;
    logic [MD_OP_W-1:0] md_op;
    logic [4:0] shamt;
    logic [XLEN-1:0] imm, rs_q, rt_q, pc_plus_4, d_rs, d_rt, alu_y, hi, lo, md_hi, md_lo;
    logic busy, md_done, load, committed;
    assign load = pipeline_ready && !busy;
    assign pipeline_valid = !busy;
    assign d_rs = s_rs_fastforward ? d_rs_fastforward : rs_q;
    assign d_rt = s_rt_fastforward ? d_rt_fastforward : rt_q;
    assign rt_bypass = d_rt;
    assign syscall_data_o = d_rt;
    assign display_data_o = d_rs;
    always_ff @(posedge clk) begin
        if (rst) begin
            s_link <= 1'b0;
            s_lui <= 1'b0;
            s_rs_bypass <= 1'b0;
            s_syscall <= 1'b0;
            s_alu_imm <= 1'b0;
            s_shamt_reg <= 1'b0;
            alu_op <= '0;
            md_op <= '0;
            shamt <= '0;
            imm <= '0;
            rs_q <= '0;
            rt_q <= '0;
            pc_plus_4 <= '0;
            s_reg_write_bus <= '0;
            s_mem_contral_bus <= '0;
        end else if (load) begin
            s_link <= !pipeline_flush && s_link_i;
            s_lui <= !pipeline_flush && s_lui_i;
            s_rs_bypass <= !pipeline_flush && s_rs_bypass_i;
            s_syscall <= !pipeline_flush && s_syscall_i;
            alu_op <= pipeline_flush ? '0 : alu_op_i;
            md_op <= pipeline_flush ? '0 : md_op_i;
            s_reg_write_bus <= pipeline_flush ? '0 : s_reg_write_bus_i;
            s_mem_contral_bus <= pipeline_flush ? '0 : s_mem_contral_bus_i;
            s_alu_imm <= s_alu_imm_i;
            s_shamt_reg <= s_shamt_reg_i;
            shamt <= shamt_i;
            imm <= extended_imm_i;
            rs_q <= d_rs_i;
            rt_q <= d_rt_i;
            pc_plus_4 <= pc_plus_4_i;
        end else if (pipeline_flush && busy) begin
            md_op <= MD_OP_W'(MD_NONE);
        end
    end
    // committed is low only during the first cycle an instruction sits in the latch
    always_ff @(posedge clk) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
            committed <= 1'b0;
        end else begin
            committed <= !load;
            if (md_done) begin
                hi <= md_hi;
                lo <= md_lo;
            end else if (!committed && int'(md_op) == MD_MTHI) hi <= d_rs;
            else if (!committed && int'(md_op) == MD_MTLO) lo <= d_rs;
        end
    end
    alu #(.XLEN(XLEN), .ALU_OP_W(ALU_OP_W)) u_alu (
        .op(alu_op),
        .a(d_rs),
        .b(s_alu_imm ? imm : d_rt),
        .shamt(s_shamt_reg ? d_rs[4:0] : shamt),
        .y(alu_y)
    );
    muldiv_iter #(.XLEN(XLEN), .MD_OP_W(MD_OP_W)) u_muldiv (
        .clk(clk),
        .rst(rst),
        .start(is_iter_op(int'(md_op)) && !committed),
        .abort(pipeline_flush),
        .op(md_op),
        .a(d_rs),
        .b(d_rt),
        .busy(busy),
        .done(md_done),
        .hi(md_hi),
        .lo(md_lo)
    );
    always_comb begin
        ex_result = s_rs_bypass ? d_rs
                  : s_lui ? {imm[XLEN/2-1:0], {(XLEN/2){1'b0}}}
                  : s_link ? pc_plus_4
                  : int'(md_op) == MD_MFHI ? hi
                  : int'(md_op) == MD_MFLO ? lo
                  : alu_y;
    end
endmodule

// File: tb/tb_ex_stage_md.sv
// tb_ex_stage_md: directed scenario tests for the mul/div execute stage.
module tb_ex_stage_md;
    import ex_stage_md_pkg::*;
    logic clk = 1'b0;
    logic rst, pipeline_flush, pipeline_ready, pipeline_valid;
    logic [31:0] pc_plus_4_i, extended_imm_i, d_rs_i, d_rt_i, d_rs_fastforward, d_rt_fastforward;
    logic s_link_i, s_lui_i, s_rs_bypass_i, s_alu_imm_i, s_shamt_reg_i, s_syscall_i;
    logic s_rs_fastforward, s_rt_fastforward, s_syscall;
    logic [3:0] alu_op_i, md_op_i;
    logic [4:0] shamt_i;
    logic [5:0] s_reg_write_bus_i, s_reg_write_bus;
    logic [3:0] s_mem_contral_bus_i, s_mem_contral_bus;
    logic [31:0] ex_result, rt_bypass, syscall_data_o, display_data_o;
    int checks = 0;
    int errors = 0;

    ex_stage_md dut (
        .clk(clk), .rst(rst), .pipeline_flush(pipeline_flush), .pipeline_ready(pipeline_ready),
        .pipeline_valid(pipeline_valid), .pc_plus_4_i(pc_plus_4_i), .s_link_i(s_link_i),
        .s_lui_i(s_lui_i), .s_rs_bypass_i(s_rs_bypass_i), .s_alu_imm_i(s_alu_imm_i),
        .s_shamt_reg_i(s_shamt_reg_i), .s_syscall_i(s_syscall_i), .alu_op_i(alu_op_i),
        .md_op_i(md_op_i), .shamt_i(shamt_i), .extended_imm_i(extended_imm_i), .d_rs_i(d_rs_i),
        .d_rt_i(d_rt_i), .s_rs_fastforward(s_rs_fastforward), .s_rt_fastforward(s_rt_fastforward),
        .d_rs_fastforward(d_rs_fastforward), .d_rt_fastforward(d_rt_fastforward),
        .s_reg_write_bus_i(s_reg_write_bus_i), .s_reg_write_bus(s_reg_write_bus),
        .s_mem_contral_bus_i(s_mem_contral_bus_i), .s_mem_contral_bus(s_mem_contral_bus),
        .ex_result(ex_result), .rt_bypass(rt_bypass), .s_syscall(s_syscall),
        .syscall_data_o(syscall_data_o), .display_data_o(display_data_o)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input int alu, input int md, input logic [31:0] rs, input logic [31:0] rt,
                             input logic [31:0] imm, input logic alu_imm);
        alu_op_i = 4'(alu);
        md_op_i = 4'(md);
        d_rs_i = rs;
        d_rt_i = rt;
        extended_imm_i = imm;
        s_alu_imm_i = alu_imm;
        s_link_i = 0;
        s_lui_i = 0;
        s_rs_bypass_i = 0;
        s_shamt_reg_i = 0;
        s_syscall_i = 0;
        shamt_i = 0;
        pc_plus_4_i = 0;
        s_reg_write_bus_i = 0;
        s_mem_contral_bus_i = 0;
        s_rs_fastforward = 0;
        s_rt_fastforward = 0;
        d_rs_fastforward = 0;
        d_rt_fastforward = 0;
    endtask

    task automatic run_md(input int md, input logic [31:0] a, input logic [31:0] b, output int cyc);
        set_instr(ALU_ADD, md, a, b, 0, 0);
        tick;
        set_instr(ALU_ADD, MD_NONE, 0, 0, 0, 0);
        cyc = 0;
        while (!pipeline_valid && cyc < 100) begin
            cyc++;
            tick;
        end
    endtask

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        set_instr(ALU_ADD, MD_MFHI, 0, 0, 0, 0);
        tick;
        h = ex_result;
        set_instr(ALU_ADD, MD_MFLO, 0, 0, 0, 0);
        tick;
        l = ex_result;
    endtask

    task automatic test_reset;
        rst = 1;
        pipeline_flush = 0;
        pipeline_ready = 1;
        set_instr(ALU_ADD, MD_NONE, 1, 2, 0, 0);
        s_syscall_i = 1;
        s_reg_write_bus_i = 6'h3F;
        s_mem_contral_bus_i = 4'hF;
        tick;
        tick;
        checks++; if (pipeline_valid !== 1'b1) begin errors++; $display("FAIL reset_valid got %b want 1", pipeline_valid); end
        checks++; if (s_syscall !== 1'b0) begin errors++; $display("FAIL reset_syscall got %b want 0", s_syscall); end
        checks++; if (s_reg_write_bus !== 6'h0) begin errors++; $display("FAIL reset_wbus got %h want 0", s_reg_write_bus); end
        checks++; if (s_mem_contral_bus !== 4'h0) begin errors++; $display("FAIL reset_mbus got %h want 0", s_mem_contral_bus); end
        set_instr(ALU_ADD, MD_NONE, 0, 0, 0, 0);
        rst = 0;
        tick;
    endtask

    task automatic test_alu;
        set_instr(ALU_ADD, MD_NONE, 5, 7, 0, 0);
        s_syscall_i = 1;
        s_reg_write_bus_i = 6'h2A;
        s_mem_contral_bus_i = 4'h5;
        tick;
        checks++; if (ex_result !== 32'd12) begin errors++; $display("FAIL alu_add got %h want c", ex_result); end
        checks++; if (pipeline_valid !== 1'b1) begin errors++; $display("FAIL alu_valid got %b want 1", pipeline_valid); end
        checks++; if (s_reg_write_bus !== 6'h2A) begin errors++; $display("FAIL alu_wbus got %h want 2a", s_reg_write_bus); end
        checks++; if (s_mem_contral_bus !== 4'h5) begin errors++; $display("FAIL alu_mbus got %h want 5", s_mem_contral_bus); end
        checks++; if (s_syscall !== 1'b1) begin errors++; $display("FAIL alu_syscall got %b want 1", s_syscall); end
        checks++; if (syscall_data_o !== 32'd7 || rt_bypass !== 32'd7 || display_data_o !== 32'd5) begin
            errors++; $display("FAIL taps got %h %h %h want 7 7 5", syscall_data_o, rt_bypass, display_data_o); end
        set_instr(ALU_SUB, MD_NONE, 3, 5, 0, 0);
        tick;
        checks++; if (ex_result !== 32'hFFFFFFFE) begin errors++; $display("FAIL alu_sub got %h want fffffffe", ex_result); end
        set_instr(ALU_SLT, MD_NONE, 32'hFFFFFFFF, 1, 0, 0);
        tick;
        checks++; if (ex_result !== 32'd1) begin errors++; $display("FAIL alu_slt got %h want 1", ex_result); end
        set_instr(ALU_SLL, MD_NONE, 0, 1, 0, 0);
        shamt_i = 4;
        tick;
        checks++; if (ex_result !== 32'd16) begin errors++; $display("FAIL alu_sll got %h want 10", ex_result); end
        set_instr(ALU_SLL, MD_NONE, 3, 1, 0, 0);
        s_shamt_reg_i = 1;
        shamt_i = 9;
        tick;
        checks++; if (ex_result !== 32'd8) begin errors++; $display("FAIL alu_sllv got %h want 8", ex_result); end
        set_instr(ALU_SRA, MD_NONE, 0, 32'h80000000, 0, 0);
        shamt_i = 4;
        tick;
        checks++; if (ex_result !== 32'hF8000000) begin errors++; $display("FAIL alu_sra got %h want f8000000", ex_result); end
    endtask

    task automatic test_flush_load;
        set_instr(ALU_SUB, MD_NONE, 2, 3, 0, 0);
        s_link_i = 1;
        s_syscall_i = 1;
        pc_plus_4_i = 32'h100;
        s_reg_write_bus_i = 6'h15;
        s_mem_contral_bus_i = 4'hA;
        pipeline_flush = 1;
        tick;
        pipeline_flush = 0;
        checks++; if (ex_result !== 32'd5) begin errors++; $display("FAIL flush_result got %h want 5", ex_result); end
        checks++; if (s_reg_write_bus !== 6'h0 || s_mem_contral_bus !== 4'h0 || s_syscall !== 1'b0) begin
            errors++; $display("FAIL flush_ctrl got %h %h %b want 0 0 0", s_reg_write_bus, s_mem_contral_bus, s_syscall); end
    endtask

    task automatic test_forward;
        set_instr(ALU_ADD, MD_NONE, 1, 0, 3, 1);
        tick;
        s_rs_fastforward = 1;
        d_rs_fastforward = 32'h10;
        #1;
        checks++; if (ex_result !== 32'h13) begin errors++; $display("FAIL fwd_rs got %h want 13", ex_result); end
        set_instr(ALU_SUB, MD_NONE, 9, 1, 0, 0);
        tick;
        s_rt_fastforward = 1;
        d_rt_fastforward = 32'd4;
        #1;
        checks++; if (ex_result !== 32'd5 || rt_bypass !== 32'd4) begin
            errors++; $display("FAIL fwd_rt got %h %h want 5 4", ex_result, rt_bypass); end
    endtask

    task automatic test_result_mux;
        set_instr(ALU_ADD, MD_NONE, 0, 0, 32'h00001234, 1);
        s_lui_i = 1;
        s_link_i = 1;
        pc_plus_4_i = 32'h100;
        tick;
        checks++; if (ex_result !== 32'h12340000) begin errors++; $display("FAIL lui got %h want 12340000", ex_result); end
        set_instr(ALU_ADD, MD_MFHI, 1, 1, 0, 0);
        s_link_i = 1;
        pc_plus_4_i = 32'h100;
        tick;
        checks++; if (ex_result !== 32'h100) begin errors++; $display("FAIL link got %h want 100", ex_result); end
        set_instr(ALU_ADD, MD_NONE, 32'h55, 0, 32'h1234, 0);
        s_rs_bypass_i = 1;
        s_lui_i = 1;
        tick;
        checks++; if (ex_result !== 32'h55) begin errors++; $display("FAIL bypass got %h want 55", ex_result); end
    endtask

    task automatic test_mthi_oneshot;
        logic [31:0] h, l;
        set_instr(ALU_ADD, MD_MTHI, 32'h11, 0, 0, 0);
        tick;
        pipeline_ready = 0;
        tick;
        s_rs_fastforward = 1;
        d_rs_fastforward = 32'h22;
        tick;
        tick;
        pipeline_ready = 1;
        read_hilo(h, l);
        checks++; if (h !== 32'h11) begin errors++; $display("FAIL mthi_once got %h want 11", h); end
    endtask

    task automatic test_mult;
        int cyc;
        logic [31:0] h, l;
        run_md(MD_MULT, 32'hFFFFFFFD, 32'd5, cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL mult_stall got %0d want 33", cyc); end
        set_instr(ALU_ADD, MD_MFLO, 0, 0, 0, 0);
        tick;
        checks++; if (ex_result !== 32'hFFFFFFF1) begin errors++; $display("FAIL mult_lo got %h want fffffff1", ex_result); end
        set_instr(ALU_ADD, MD_MFHI, 0, 0, 0, 0);
        tick;
        checks++; if (ex_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi got %h want ffffffff", ex_result); end
        run_md(MD_MULTU, 32'hFFFFFFFF, 32'd2, cyc);
        read_hilo(h, l);
        checks++; if (h !== 32'd1 || l !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu got %h %h want 1 fffffffe", h, l); end
    endtask

    task automatic test_div;
        int cyc;
        logic [31:0] h, l;
        run_md(MD_DIV, 32'd7, 32'hFFFFFFFE, cyc);
        checks++; if (cyc !== 33) begin errors++; $display("FAIL div_stall got %0d want 33", cyc); end
        read_hilo(h, l);
        checks++; if (h !== 32'd1 || l !== 32'hFFFFFFFD) begin errors++; $display("FAIL div got %h %h want 1 fffffffd", h, l); end
        run_md(MD_DIVU, 32'd10, 32'd0, cyc);
        read_hilo(h, l);
        checks++; if (h !== 32'd10 || l !== 32'hFFFFFFFF) begin errors++; $display("FAIL divu0 got %h %h want a ffffffff", h, l); end
        run_md(MD_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
        read_hilo(h, l);
        checks++; if (h !== 32'd0 || l !== 32'h80000000) begin errors++; $display("FAIL div_ovf got %h %h want 0 80000000", h, l); end
        run_md(MD_DIV, 32'hFFFFFFF9, 32'd2, cyc);
        read_hilo(h, l);
        checks++; if (h !== 32'hFFFFFFFF || l !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg got %h %h want ffffffff fffffffd", h, l); end
        run_md(MD_DIVU, 32'd100, 32'd7, cyc);
        read_hilo(h, l);
        checks++; if (h !== 32'd2 || l !== 32'd14) begin errors++; $display("FAIL divu got %h %h want 2 e", h, l); end
    endtask

    task automatic test_abort;
        logic [31:0] h, l;
        set_instr(ALU_ADD, MD_MTHI, 32'hA5A5A5A5, 0, 0, 0);
        tick;
        set_instr(ALU_ADD, MD_MTLO, 32'hA5A5A5A5, 0, 0, 0);
        tick;
        set_instr(ALU_ADD, MD_MULT, 3, 5, 0, 0);
        tick;
        set_instr(ALU_ADD, MD_NONE, 0, 0, 0, 0);
        checks++; if (pipeline_valid !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", pipeline_valid); end
        repeat (4) tick;
        pipeline_flush = 1;
        tick;
        pipeline_flush = 0;
        checks++; if (pipeline_valid !== 1'b1) begin errors++; $display("FAIL abort_valid got %b want 1", pipeline_valid); end
        tick;
        checks++; if (pipeline_valid !== 1'b1) begin errors++; $display("FAIL abort_hold got %b want 1", pipeline_valid); end
        read_hilo(h, l);
        checks++; if (h !== 32'hA5A5A5A5 || l !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL abort_hilo got %h %h want a5a5a5a5 a5a5a5a5", h, l); end
    endtask

    task automatic test_reset_mid_div;
        logic [31:0] h, l;
        set_instr(ALU_ADD, MD_DIV, 100, 7, 0, 0);
        s_reg_write_bus_i = 6'h3;
        s_mem_contral_bus_i = 4'h3;
        s_syscall_i = 1;
        tick;
        repeat (9) tick;
        checks++; if (pipeline_valid !== 1'b0) begin errors++; $display("FAIL rdiv_busy got %b want 0", pipeline_valid); end
        rst = 1;
        tick;
        checks++; if (pipeline_valid !== 1'b1 || s_syscall !== 1'b0) begin
            errors++; $display("FAIL rdiv_state got %b %b want 1 0", pipeline_valid, s_syscall); end
        checks++; if (s_reg_write_bus !== 6'h0 || s_mem_contral_bus !== 4'h0) begin
            errors++; $display("FAIL rdiv_bus got %h %h want 0 0", s_reg_write_bus, s_mem_contral_bus); end
        set_instr(ALU_ADD, MD_NONE, 0, 0, 0, 0);
        rst = 0;
        tick;
        checks++; if (pipeline_valid !== 1'b1) begin errors++; $display("FAIL rdiv_valid got %b want 1", pipeline_valid); end
        read_hilo(h, l);
        checks++; if (h !== 32'd0 || l !== 32'd0) begin errors++; $display("FAIL rdiv_hilo got %h %h want 0 0", h, l); end
    endtask

    initial begin
        test_reset;
        test_alu;
        test_flush_load;
        test_forward;
        test_result_mux;
        test_mthi_oneshot;
        test_mult;
        test_div;
        test_abort;
        test_reset_mid_div;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
